// File: rtl/dma_channel.sv
// dma_channel: single-channel MSP430 bus-master block copy engine; define DMA_ABORT_EN to add the abort input
module dma_channel #(
  parameter int BURST = 4
) (
  input  logic        MCLK,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] SRC,
  input  logic [15:0] DST,
  input  logic [15:0] CNT,
  input  logic        SRCINC,
  input  logic        DSTINC,
  input  logic        BYTE,
  input  logic        BUSGNT,
  input  logic [15:0] MDBread,
`ifdef DMA_ABORT_EN
  input  logic        abort,
`endif
  output logic        BUSREQ,
  output logic [15:0] MAB,
  output logic [15:0] MDBwrite,
  output logic        MW,
  output logic        BW,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, YIELD, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, data_q, data_d, step;
  logic [7:0] burst_q, burst_d;
  logic srcinc_q, srcinc_d, dstinc_q, dstinc_d, byte_q, byte_d, kill;
`ifdef DMA_ABORT_EN
  assign kill = abort && state_q != IDLE && state_q != DONE;
`else
  assign kill = 1'b0;
`endif
  assign step = byte_q ? 16'd1 : 16'd2;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    data_d = data_q;
    burst_d = burst_q;
    srcinc_d = srcinc_q;
    dstinc_d = dstinc_q;
    byte_d = byte_q;
    case (state_q)
      IDLE: if (start) begin
        src_d = BYTE ? SRC : {SRC[15:1], 1'b0};
        dst_d = BYTE ? DST : {DST[15:1], 1'b0};
        cnt_d = CNT;
        srcinc_d = SRCINC;
        dstinc_d = DSTINC;
        byte_d = BYTE;
        burst_d = 8'd0;
        state_d = CNT == 16'd0 ? DONE : REQ;
      end
      REQ: state_d = BUSGNT ? READ : REQ;
      READ: begin
        data_d = byte_q ? {8'h00, MDBread[7:0]} : MDBread;
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q - 16'd1;
        src_d = srcinc_q ? src_q + step : src_q;
        dst_d = dstinc_q ? dst_q + step : dst_q;
        burst_d = burst_q + 8'd1;
        state_d = cnt_d == 16'd0 ? DONE : burst_d == 8'(BURST) ? YIELD : READ;
        burst_d = state_d == YIELD ? 8'd0 : burst_d;
      end
      YIELD: state_d = REQ;
      default: state_d = IDLE;
    endcase
    state_d = kill ? IDLE : state_d;
  end
  always_ff @(posedge MCLK) begin
    if (rst) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      burst_q <= '0;
      srcinc_q <= 1'b0;
      dstinc_q <= 1'b0;
      byte_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      burst_q <= burst_d;
      srcinc_q <= srcinc_d;
      dstinc_q <= dstinc_d;
      byte_q <= byte_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign BUSREQ = state_q == REQ || state_q == READ || state_q == WRITE;
  assign MW = state_q == WRITE;
  assign MAB = state_q == READ ? src_q : MW ? dst_q : 16'h0000;
  assign MDBwrite = MW ? data_q : 16'h0000;
  assign BW = (state_q == READ || MW) && byte_q;
endmodule
